// File: rtl/count_display_pkg.sv
// count_display_pkg: shared types and constants for the count display driver.
package count_display_pkg;

    localparam int unsigned BIN_W     = 8;
    localparam int unsigned BCD_W     = 12;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned SEG_W     = 7;
    localparam int unsigned AN_W      = 4;
    localparam int unsigned ITER_W    = 4;
    localparam int unsigned PRESC_W   = 16;
    localparam int unsigned SLOT_COUNT = 4;
    localparam int unsigned SLOT_W    = $clog2(SLOT_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;

    // Double-dabble nibble correction applied before each shift
    function automatic logic [NIB_W-1:0] dd_adjust(input logic [NIB_W-1:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low seven-segment pattern, with blanking.
module seg7_decode
    import count_display_pkg::*;
(
    input  logic [NIB_W-1:0] digit,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_c
);

    // Blank or non-decimal nibbles turn every segment off
    always_comb begin
        seg_c = SEG_OFF;
        if (!blank) begin
            case (digit)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: samples Y, converts to BCD by double-dabble, and
// scans it onto a 4-digit active-low common-anode display (slot 3 is dark).
// Optional: define COUNT_DISPLAY_LEAD_BLANK_EN to blank leading zeros.
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             trigger,
    input  logic             reset_n,
    input  logic [BIN_W-1:0] Y,
    output logic [SEG_W-1:0] seg,
    output logic [AN_W-1:0]  an,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid,
    output logic             busy
);

    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(SCAN_DIV - 1);

    conv_state_e        state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               busy_q, busy_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SLOT_W-1:0]  digit_idx_q, digit_idx_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [AN_W-1:0]    an_q, an_d;

    logic [BCD_W-1:0]   adjusted_c;
    logic               tick_c;
    logic [NIB_W-1:0]   dec_digit_c;
    logic               dec_blank_c;
    logic [SEG_W-1:0]   dec_seg_c;
    logic               blank_hund_c;
    logic               blank_tens_c;

    // Conversion FSM: IDLE -> LOAD -> SHIFT x8 -> DONE -> IDLE
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        adjusted_c  = {dd_adjust(scratch_q[11:8]),
                       dd_adjust(scratch_q[7:4]),
                       dd_adjust(scratch_q[3:0])};
        case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                bin_d     = Y;
                scratch_d = '0;
                iter_d    = ITER_W'(8);
                state_d   = SHIFT;
            end
            SHIFT: begin
                {scratch_d, bin_d} = {adjusted_c, bin_q} << 1;
                iter_d = iter_q - ITER_W'(1);
                if (iter_q == ITER_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef COUNT_DISPLAY_LEAD_BLANK_EN
    assign blank_hund_c = (bcd_q[11:8] == 4'd0);
    assign blank_tens_c = (bcd_q[11:4] == 8'd0);
`else
    assign blank_hund_c = 1'b0;
    assign blank_tens_c = 1'b0;
`endif

    // Scan prescaler, slot selection and digit/anode selection from bcd
    always_comb begin
        tick_c      = (presc_q == PRESC_TERM);
        presc_d     = tick_c ? '0 : presc_q + PRESC_W'(1);
        digit_idx_d = tick_c ? digit_idx_q + SLOT_W'(1) : digit_idx_q;
        dec_digit_c = '0;
        dec_blank_c = 1'b1;
        an_d        = 4'b1111;
        case (digit_idx_q)
            2'd0: begin
                dec_digit_c = bcd_q[3:0];
                dec_blank_c = 1'b0;
                an_d        = 4'b1110;
            end
            2'd1: begin
                dec_digit_c = bcd_q[7:4];
                dec_blank_c = blank_tens_c;
                an_d        = blank_tens_c ? 4'b1111 : 4'b1101;
            end
            2'd2: begin
                dec_digit_c = bcd_q[11:8];
                dec_blank_c = blank_hund_c;
                an_d        = blank_hund_c ? 4'b1111 : 4'b1011;
            end
            default: begin
                dec_digit_c = '0;
                dec_blank_c = 1'b1;
                an_d        = 4'b1111;
            end
        endcase
        seg_d = dec_seg_c;
    end

    seg7_decode u_dec (
        .digit (dec_digit_c),
        .blank (dec_blank_c),
        .seg_c (dec_seg_c)
    );

    // State and output registers
    always_ff @(posedge trigger or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            iter_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            presc_q     <= '0;
            digit_idx_q <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= 4'hF;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            busy_q      <= busy_d;
            presc_q     <= presc_d;
            digit_idx_q <= digit_idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_count_display_driver.sv
// tb_count_display_driver: directed checks of conversion, scan and reset.
// Build with COUNT_DISPLAY_LEAD_BLANK_EN defined to check leading blanking.
`timescale 1ns/1ps
module tb_count_display_driver;

    logic       trigger;
    logic       reset_n;
    logic [7:0] y_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic [11:0] bcd;
    logic       bcd_valid;
    logic       busy;

    int n_checks;
    int n_fail;

    count_display_driver #(.SCAN_DIV(2)) dut (
        .trigger   (trigger),
        .reset_n   (reset_n),
        .Y         (y_in),
        .seg       (seg),
        .an        (an),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    initial trigger = 1'b0;
    always #5 trigger = ~trigger;

    // Wait (bounded) for bcd_valid; cycles counted in posedges, sampled at negedge
    task automatic wait_valid(output int cyc, output int low_busy);
        bit found;
        found = 0;
        cyc = 0;
        low_busy = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge trigger);
            @(negedge trigger);
            cyc++;
            if (bcd_valid === 1'b1) found = 1;
            else if (busy !== 1'b1) low_busy++;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: no bcd_valid within 40 cycles");
        end
    endtask

    // Wait (bounded) for the first cycle of slot 0 (an 1111 -> 1110)
    task automatic sync_slot0();
        logic [3:0] prev;
        bit found;
        found = 0;
        prev = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge trigger);
            if (prev === 4'b1111 && an === 4'b1110) found = 1;
            prev = an;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL scan_sync: slot 0 never started");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        y_in = 8'd0;
        repeat (2) @(negedge trigger);
        n_checks++;
        if ({busy, bcd_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: busy,valid=%b required 00", {busy, bcd_valid});
        end
        n_checks++;
        if (bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_bcd: got %h required 000", bcd);
        end
        n_checks++;
        if (seg !== 7'h7F || an !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_display: seg=%h an=%b required 7f 1111", seg, an);
        end
    endtask

    task automatic test_zero_max();
        int cyc, lowb;
        reset_n = 1'b1;
        y_in = 8'd0;
        wait_valid(cyc, lowb);
        n_checks++;
        if (cyc != 11) begin
            n_fail++;
            $display("FAIL first_latency: got %0d edges required 11", cyc);
        end
        n_checks++;
        if (bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL conv_zero: got %h required 000", bcd);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_gap_low: got %b required 0", busy);
        end
        y_in = 8'd255;
        wait_valid(cyc, lowb);
        n_checks++;
        if (cyc != 11) begin
            n_fail++;
            $display("FAIL conv_period: got %0d required 11", cyc);
        end
        n_checks++;
        if (lowb != 0) begin
            n_fail++;
            $display("FAIL busy_during_conv: low cycles %0d required 0", lowb);
        end
        n_checks++;
        if (bcd !== 12'h255) begin
            n_fail++;
            $display("FAIL conv_255: got %h required 255", bcd);
        end
    endtask

    task automatic test_mid_change();
        int cyc, lowb;
        y_in = 8'd42;
        repeat (3) @(posedge trigger);
        @(negedge trigger);
        y_in = 8'd99;
        wait_valid(cyc, lowb);
        n_checks++;
        if (bcd !== 12'h042) begin
            n_fail++;
            $display("FAIL mid_change_cur: got %h required 042", bcd);
        end
        wait_valid(cyc, lowb);
        n_checks++;
        if (bcd !== 12'h099) begin
            n_fail++;
            $display("FAIL mid_change_next: got %h required 099", bcd);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, lowb;
        repeat (5) @(posedge trigger);
        @(negedge trigger);
        reset_n = 1'b0;
        #0.5;
        n_checks++;
        if ({busy, bcd_valid, bcd, seg, an} !== {1'b0, 1'b0, 12'h000, 7'h7F, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_async: busy=%b valid=%b bcd=%h seg=%h an=%b required 0 0 000 7f 1111",
                     busy, bcd_valid, bcd, seg, an);
        end
        #0.5;
        reset_n = 1'b1;
        wait_valid(cyc, lowb);
        n_checks++;
        if (cyc != 11) begin
            n_fail++;
            $display("FAIL reset_restart_latency: got %0d edges required 11", cyc);
        end
        n_checks++;
        if (bcd !== 12'h099) begin
            n_fail++;
            $display("FAIL reset_restart_value: got %h required 099", bcd);
        end
    endtask

    task automatic test_exhaustive();
        int cyc, lowb;
        logic [11:0] exp_bcd;
        for (int y = 0; y < 256; y++) begin
            y_in = 8'(y);
            wait_valid(cyc, lowb);
            exp_bcd = {4'(y / 100), 4'((y / 10) % 10), 4'(y % 10)};
            n_checks++;
            if (bcd !== exp_bcd) begin
                n_fail++;
                $display("FAIL conv_sweep y=%0d: got %h required %h", y, bcd, exp_bcd);
            end
        end
    endtask

    task automatic test_scan();
        int cyc, lowb;
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        int slot;
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0000000;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b0100100;
        exp_an[2] = 4'b1011; exp_seg[2] = 7'b1111001;
        exp_an[3] = 4'b1111; exp_seg[3] = 7'h7F;
        y_in = 8'd128;
        wait_valid(cyc, lowb);
        wait_valid(cyc, lowb);
        sync_slot0();
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge trigger);
            slot = (k / 2) % 4;
            n_checks++;
            if (an !== exp_an[slot] || seg !== exp_seg[slot]) begin
                n_fail++;
                $display("FAIL scan_seq k=%0d: an=%b seg=%b required an=%b seg=%b",
                         k, an, seg, exp_an[slot], exp_seg[slot]);
            end
        end
    endtask

    task automatic test_lead_blank();
        int cyc, lowb;
        logic [3:0] exp_an [3];
        logic [6:0] exp_seg [3];
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b1111000;
`ifdef COUNT_DISPLAY_LEAD_BLANK_EN
        exp_an[1] = 4'b1111; exp_seg[1] = 7'h7F;
        exp_an[2] = 4'b1111; exp_seg[2] = 7'h7F;
`else
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b1000000;
        exp_an[2] = 4'b1011; exp_seg[2] = 7'b1000000;
`endif
        y_in = 8'd7;
        wait_valid(cyc, lowb);
        wait_valid(cyc, lowb);
        n_checks++;
        if (bcd !== 12'h007) begin
            n_fail++;
            $display("FAIL blank_bcd: got %h required 007", bcd);
        end
        sync_slot0();
        for (int s = 0; s < 3; s++) begin
            if (s > 0) repeat (2) @(negedge trigger);
            n_checks++;
            if (an !== exp_an[s] || seg !== exp_seg[s]) begin
                n_fail++;
                $display("FAIL lead_blank slot%0d: an=%b seg=%b required an=%b seg=%b",
                         s, an, seg, exp_an[s], exp_seg[s]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_zero_max();
        test_mid_change();
        test_reset_mid();
        test_exhaustive();
        test_scan();
        test_lead_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
